// File: rtl/ram8_pkg.sv
// Shared types and constants for the two-requester, 8-word RAM arbiter.
package ram8_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int NREQ       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot2(input logic idx);
    logic [NREQ-1:0] oh;
    if (idx) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not win last time is granted.
module rr_arbiter2
  import ram8_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_gnt,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  // One-hot grant from the current request vector and the fairness pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    any = |req;
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Arbitrates two requesters onto a single-port 8-word RAM: IDLE -> ACCESS -> RESP, one access per 3 cycles.
module ram8_arbiter
  import ram8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_W-1:0]    addr,
  input  logic [2*DATA_W-1:0]    wdata,
  output logic [1:0]             ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic                   ram_en,
  output logic                   ram_rw,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  input  logic [DATA_W-1:0]      ram_dout
);

  state_t            state;
  logic              last_gnt;
  logic              gnt_id;
  logic              en_q;
  logic              rw_q;
  logic [1:0]        gnt;
  logic              any_req;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .any      (any_req)
  );

  // Select the winning requester's operation fields
  always_comb begin
    win = gnt[1];
    if (win) begin
      win_we    = we[1];
      win_addr  = addr[ADDR_W +: ADDR_W];
      win_wdata = wdata[DATA_W +: DATA_W];
    end else begin
      win_we    = we[0];
      win_addr  = addr[0 +: ADDR_W];
      win_wdata = wdata[0 +: DATA_W];
    end
  end

  // Main FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      ack      <= 2'b00;
      busy     <= 1'b0;
      ram_addr <= {ADDR_W{1'b0}};
      ram_din  <= {DATA_W{1'b0}};
      rdata    <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          ack <= 2'b00;
          if (any_req) begin
            state    <= ACCESS;
            gnt_id   <= win;
            last_gnt <= win;
            en_q     <= 1'b1;
            rw_q     <= win_we;
            busy     <= 1'b1;
            ram_addr <= win_addr;
            ram_din  <= win_wdata;
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          state <= RESP;
          en_q  <= 1'b0;
          rw_q  <= 1'b0;
          ack   <= onehot2(gnt_id);
          if (!rw_q) begin
            rdata <= ram_dout;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 2'b00;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          en_q  <= 1'b0;
          rw_q  <= 1'b0;
          ack   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Reset cancels the RAM strobe in the very cycle it is raised, so an aborted write never lands
  assign ram_en = en_q & ~rst;
  assign ram_rw = rw_q & ~rst;

endmodule
